// File: rtl/gf128_sqr_chain_ctrl_if.sv
// Request/response bundle for the GF(2^128) repeated-squaring chain.
// The abort signal exists only when SQR_CHAIN_ABORT_EN is defined.
interface gf128_sqr_chain_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [127:0]     operand;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic [127:0]     result;
`ifdef SQR_CHAIN_ABORT_EN
    logic             abort;

    modport master (output start, operand, count, abort, input busy, done, result);
    modport slave  (input start, operand, count, abort, output busy, done, result);
`else
    modport master (output start, operand, count, input busy, done, result);
    modport slave  (input start, operand, count, output busy, done, result);
`endif
endinterface

// File: rtl/gf128_sqr_chain_ctrl.sv
// Repeated squaring a^(2^k) in GF(2^128) mod x^128+x^7+x^2+x+1, one squaring per cycle.
// Optional SQR_CHAIN_ABORT_EN adds an abort input that cancels a running chain.
module gf128_sqr_chain_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gf128_sqr_chain_ctrl_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [127:0]     w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     result_q, result_d;
    logic             done_q, done_d;
    logic [127:0]     sqr_w;
    logic             abort_req;

    // Squaring over GF(2) is carry-free: bit i moves to bit 2i.
    function automatic logic [255:0] sqr(input logic [127:0] a);
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < 128; i++) p[2*i] = a[i];
        return p;
    endfunction

    function automatic logic [127:0] reduce(input logic [255:0] p);
        logic [127:0] h;
        logic [134:0] t;
        logic [6:0]   g;
        h = p[255:128];
        t = {7'b0, p[127:0]} ^ {7'b0, h} ^ {6'b0, h, 1'b0} ^ {5'b0, h, 2'b0} ^ {h, 7'b0};
        g = t[134:128];
        return t[127:0] ^ {121'b0, g} ^ {120'b0, g, 1'b0} ^ {119'b0, g, 2'b0} ^ {114'b0, g, 7'b0};
    endfunction

    assign sqr_w = reduce(sqr(w_q));

`ifdef SQR_CHAIN_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            w_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every signal gets a hold default before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) begin
                        result_d = bus.operand;
                        done_d   = 1'b1;
                    end else begin
                        w_d     = bus.operand;
                        cnt_d   = bus.count;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Abort takes priority over completion and leaves result untouched.
                if (abort_req) begin
                    state_d = IDLE;
                end else begin
                    w_d   = sqr_w;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = sqr_w;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state_q == RUN);
        bus.done   = done_q;
        bus.result = result_q;
    end

endmodule

// File: tb/tb_gf128_sqr_chain_ctrl.sv
// Directed bench for gf128_sqr_chain_ctrl; abort checks run when SQR_CHAIN_ABORT_EN is defined.
module tb_gf128_sqr_chain_ctrl;
    localparam int CNT_W = 8;
    localparam logic [127:0] R_VAL = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] X64   = 128'h1_0000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gf128_sqr_chain_ctrl_if #(.CNT_W(CNT_W)) sif ();
    gf128_sqr_chain_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; lat counts negedges since start was driven.
    task automatic wait_done(input int lat0, input int budget, output int lat,
                             output int busy_cycles, output bit seen);
        lat = lat0; busy_cycles = 0; seen = 1'b0;
        while (lat <= budget) begin
            if (sif.done) begin
                seen = 1'b1;
                break;
            end
            if (sif.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_chain(input string tag, input logic [127:0] op,
                             input logic [CNT_W-1:0] k, input logic [127:0] exp);
        int lat, bc, exp_lat;
        bit seen;
        sif.start = 1'b1; sif.operand = op; sif.count = k;
        @(negedge clk);
        sif.start = 1'b0; sif.operand = '0; sif.count = '0;
        wait_done(1, 300, lat, bc, seen);
        exp_lat = (k == '0) ? 1 : int'(k) + 1;
        check({tag, " done seen"}, 128'(seen), 128'd1);
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " busy cycles"}, 128'(bc), 128'(k));
        check({tag, " busy low at done"}, 128'(sif.busy), 128'd0);
        check({tag, " result"}, sif.result, exp);
        @(negedge clk);
        check({tag, " done one cycle"}, 128'(sif.done), 128'd0);
        check({tag, " result held"}, sif.result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bc;
        bit seen;
        rst_n = 1'b0;
        sif.start = 1'b0; sif.operand = '0; sif.count = '0;
`ifdef SQR_CHAIN_ABORT_EN
        sif.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset busy", 128'(sif.busy), 128'd0);
        check("reset done", 128'(sif.done), 128'd0);
        check("reset result", sif.result, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_chain("one k5", 128'h1, 8'd5, 128'h1);
        run_chain("x k6", 128'h2, 8'd6, X64);
        run_chain("x k7", 128'h2, 8'd7, 128'h87);
        run_chain("x k8", 128'h2, 8'd8, 128'h4015);
        run_chain("x k9", 128'h2, 8'd9, 128'h1000_0111);
        run_chain("x64 k1", X64, 8'd1, 128'h87);
        run_chain("frobenius k128", R_VAL, 8'd128, R_VAL);
        run_chain("one k255", 128'h1, 8'd255, 128'h1);
        run_chain("k0", 128'hDEAD_BEEF, 8'd0, 128'hDEAD_BEEF);

        // Start pulse while busy must be ignored; start on the done cycle is accepted.
        sif.start = 1'b1; sif.operand = 128'h2; sif.count = 8'd7;
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sif.start = 1'b1; sif.operand = 128'hFFFF; sif.count = 8'd3;
        @(negedge clk);
        sif.start = 1'b0; sif.operand = '0; sif.count = '0;
        wait_done(4, 50, lat, bc, seen);
        check("b2b first seen", 128'(seen), 128'd1);
        check("b2b first latency", 128'(lat), 128'd8);
        check("b2b first result", sif.result, 128'h87);
        sif.start = 1'b1; sif.operand = 128'h2; sif.count = 8'd6;
        @(negedge clk);
        sif.start = 1'b0; sif.operand = '0; sif.count = '0;
        check("b2b second busy", 128'(sif.busy), 128'd1);
        wait_done(1, 50, lat, bc, seen);
        check("b2b second seen", 128'(seen), 128'd1);
        check("b2b second latency", 128'(lat), 128'd7);
        check("b2b second result", sif.result, X64);
        @(negedge clk);

        // Reset in the middle of a 10-step chain.
        sif.start = 1'b1; sif.operand = 128'h2; sif.count = 8'd10;
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", 128'(sif.busy), 128'd0);
        check("midrun reset done", 128'(sif.done), 128'd0);
        check("midrun reset result", sif.result, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(0, 20, lat, bc, seen);
        check("no done after reset", 128'(seen), 128'd0);
        check("no busy after reset", 128'(bc), 128'd0);

`ifdef SQR_CHAIN_ABORT_EN
        run_chain("pre-abort x k7", 128'h2, 8'd7, 128'h87);
        sif.start = 1'b1; sif.operand = 128'h2; sif.count = 8'd10;
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        check("abort busy", 128'(sif.busy), 128'd0);
        check("abort done", 128'(sif.done), 128'd0);
        check("abort result kept", sif.result, 128'h87);
        wait_done(0, 20, lat, bc, seen);
        check("no done after abort", 128'(seen), 128'd0);
        sif.start = 1'b1; sif.abort = 1'b1; sif.operand = 128'h1; sif.count = 8'd2;
        @(negedge clk);
        sif.start = 1'b0; sif.abort = 1'b0; sif.operand = '0; sif.count = '0;
        check("start beats idle abort", 128'(sif.busy), 128'd1);
        wait_done(1, 50, lat, bc, seen);
        check("start+abort latency", 128'(lat), 128'd3);
        check("start+abort result", sif.result, 128'h1);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
